acc_f32: RTL and testbench



---
 rtl/acc_f32.sv | 139 +++++++++++++
 tb/tb_acc_f32.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_f32.sv
// Streaming f32 sum-reduction front end: feeds an external adder with
// running-sum + element and returns one sum per in_last-terminated frame.
module acc_f32 #(
    parameter int ADD_DELAY = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] add_a,
    output logic [31:0] add_b,
    output logic        add_t,
    input  logic [31:0] add_out
);

    localparam int CW = (ADD_DELAY < 2) ? 1 : $clog2(ADD_DELAY);
    localparam logic [CW-1:0] CNT_LAST = CW'(ADD_DELAY - 1);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ACC   = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   acc_q, acc_d;
    logic [31:0]   out_data_q, out_data_d;
    logic [31:0]   add_a_q, add_a_d;
    logic [31:0]   add_b_q, add_b_d;
    logic          add_t_q, add_t_d;
    logic          last_r_q, last_r_d;
    logic          in_ready_q, in_ready_d;
    logic          out_valid_q, out_valid_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          in_xfer;
    logic          out_xfer;

    assign in_xfer  = in_valid && in_ready_q;
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        add_a_d    = add_a_q;
        add_b_d    = add_b_q;
        add_t_d    = 1'b0;
        last_r_d   = last_r_q;
        cnt_d      = cnt_q;

        case (state_q)
            EMPTY: begin
                // First element bypasses the adder so it is passed bit-exact.
                if (in_xfer) begin
                    acc_d = in_data;
                    if (in_last) begin
                        out_data_d = in_data;
                        state_d    = DONE;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (in_xfer) begin
                    add_a_d  = acc_q;
                    add_b_d  = in_data;
                    last_r_d = in_last;
                    add_t_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q + CW'(1);
                // cnt_q == ADD_DELAY-1 marks the ADD_DELAY-th edge after issue.
                if (cnt_q == CNT_LAST) begin
                    acc_d = add_out;
                    if (last_r_q) begin
                        out_data_d = add_out;
                        state_d    = DONE;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            DONE: begin
                if (out_xfer) begin
                    acc_d   = '0;
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase

        in_ready_d  = (state_d == EMPTY) || (state_d == ACC);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= EMPTY;
            acc_q       <= '0;
            out_data_q  <= '0;
            add_a_q     <= '0;
            add_b_q     <= '0;
            add_t_q     <= 1'b0;
            last_r_q    <= 1'b0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            out_data_q  <= out_data_d;
            add_a_q     <= add_a_d;
            add_b_q     <= add_b_d;
            add_t_q     <= add_t_d;
            last_r_q    <= last_r_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            cnt_q       <= cnt_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign add_a     = add_a_q;
    assign add_b     = add_b_q;
    assign add_t     = add_t_q;

endmodule

// File: tb/tb_acc_f32.sv
// Directed bench for acc_f32 with a latency-exact adder model (small
// non-negative integer values only); second instance covers ADD_DELAY=1.
module tb_acc_f32;

    localparam logic [31:0] F1  = 32'h3F800000;
    localparam logic [31:0] F2  = 32'h40000000;
    localparam logic [31:0] F3  = 32'h40400000;
    localparam logic [31:0] F4  = 32'h40800000;
    localparam logic [31:0] F6  = 32'h40C00000;
    localparam logic [31:0] F16 = 32'h41800000;
    localparam logic [31:0] JUNK = 32'hDEADBEEF;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid, in_ready, in_last, out_valid, out_ready, add_t;
    logic [31:0] in_data, out_data, add_a, add_b, add_out;

    logic        in_valid1, in_ready1, in_last1, out_valid1, out_ready1, add_t1;
    logic [31:0] in_data1, out_data1, add_a1, add_b1, add_out1;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int dbl    = 0;
    logic prev_t = 1'b0;

    always #5 clk = ~clk;

    acc_f32 #(.ADD_DELAY(5)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .add_a(add_a), .add_b(add_b), .add_t(add_t), .add_out(add_out)
    );

    acc_f32 #(.ADD_DELAY(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1), .in_last(in_last1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
        .add_a(add_a1), .add_b(add_b1), .add_t(add_t1), .add_out(add_out1)
    );

    function automatic logic [31:0] f2i(input logic [31:0] x);
        logic [31:0] m;
        if (x[30:0] == 31'd0) return 32'd0;
        m = {8'd0, 1'b1, x[22:0]};
        return m >> (150 - int'(x[30:23]));
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] s, t;
        int p;
        s = f2i(a) + f2i(b);
        if (s == 32'd0) return 32'd0;
        p = 31;
        while (!s[p]) p--;
        t = s << (23 - p);
        return {1'b0, 8'(p + 127), t[22:0]};
    endfunction

    // Adder model: result is valid only during the cycle the DUT must sample it.
    logic [31:0] pipe [0:3];
    always @(posedge clk) begin
        pipe[0] <= add_t ? fadd(add_a, add_b) : JUNK;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
    end
    assign add_out  = pipe[3];
    assign add_out1 = add_t1 ? fadd(add_a1, add_b1) : JUNK;

    always @(negedge clk) begin
        if (add_t) begin
            pulses++;
            if (prev_t) dbl++;
        end
        prev_t = add_t;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end else begin
            $display("ok   %s: %h", tag, got);
        end
    endtask

    task automatic send(input logic [31:0] d, input logic last, output int waits);
        waits = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && waits < 50) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready) begin
            check("send_timeout", 64'd0, 64'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // lat counts edges from the accepting edge until out_valid is seen.
    task automatic wait_out(output logic [31:0] data, output int lat);
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) check("out_timeout", 64'd0, 64'd1);
        data = out_data;
    endtask

    logic [31:0] d;
    int w, lat, p0, d0, n;

    initial begin
        rst = 1'b1;
        in_valid = 0; in_data = 0; in_last = 0; out_ready = 0;
        in_valid1 = 0; in_data1 = 0; in_last1 = 0; out_ready1 = 0;
        repeat (3) @(negedge clk);
        check("reset_flags", {61'd0, in_ready, out_valid, add_t}, 64'd0);
        check("reset_data", {out_data, add_a}, 64'd0);
        check("reset_addb", {32'd0, add_b}, 64'd0);
        rst = 1'b0;
        #1 check("ready_low_after_rst", {63'd0, in_ready}, 64'd0);
        @(negedge clk);
        check("ready_rises", {63'd0, in_ready}, 64'd1);

        // 1 + 2 + 3
        out_ready = 1'b1;
        send(F1, 1'b0, w);
        send(F2, 1'b0, w);
        check("first_elem_no_stall", 64'(w), 64'd0);
        send(F3, 1'b1, w);
        check("ready_low_after_2nd", 64'(w), 64'd5);
        wait_out(d, lat);
        check("sum_1_2_3", {32'd0, d}, {32'd0, F6});
        check("latency_5", 64'(lat), 64'd6);
        @(posedge clk);
        #1 check("handoff_clears_valid", {63'd0, out_valid}, 64'd0);

        // single -0 element passes bit-exact without adder use
        p0 = pulses;
        send(32'h80000000, 1'b1, w);
        wait_out(d, lat);
        check("neg_zero_exact", {32'd0, d}, 64'h80000000);
        check("single_latency", 64'(lat), 64'd1);
        @(posedge clk);
        #1 check("single_no_add_t", 64'(pulses - p0), 64'd0);

        // backpressure: sum held 10 cycles while next frame waits
        out_ready = 1'b0;
        send(F1, 1'b0, w);
        send(F1, 1'b1, w);
        wait_out(d, lat);
        check("sum_1_1", {32'd0, d}, {32'd0, F2});
        in_valid = 1'b1; in_data = F4; in_last = 1'b1;
        n = 0;
        for (int i = 0; i < 10; i++) begin
            if ({out_valid, in_ready, out_data} !== {1'b1, 1'b0, F2}) n++;
            @(negedge clk);
        end
        check("hold_10_cycles", 64'(n), 64'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        in_valid = 1'b0;
        send(F4, 1'b1, w);
        wait_out(d, lat);
        check("next_frame_4", {32'd0, d}, {32'd0, F4});
        out_ready = 1'b1;
        @(posedge clk);

        // reset during WAIT with an add in flight
        send(F1, 1'b0, w);
        send(F2, 1'b0, w);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_wait_flags", {61'd0, in_ready, out_valid, add_t}, 64'd0);
        check("rst_wait_ops", {add_a, add_b}, 64'd0);
        check("rst_wait_out", {32'd0, out_data}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(F2, 1'b1, w);
        wait_out(d, lat);
        check("post_rst_frame", {32'd0, d}, {32'd0, F2});
        @(posedge clk);

        // 16 x 1.0 with random input gaps
        p0 = pulses;
        d0 = dbl;
        for (int i = 0; i < 16; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            send(F1, (i == 15), w);
        end
        wait_out(d, lat);
        check("sum_16", {32'd0, d}, {32'd0, F16});
        @(posedge clk);
        #1;
        check("add_t_pulses", 64'(pulses - p0), 64'd15);
        check("add_t_single_cycle", 64'(dbl - d0), 64'd0);

        // ADD_DELAY=1 instance: 1 + 2
        out_ready1 = 1'b1;
        @(negedge clk);
        in_valid1 = 1'b1; in_data1 = F1; in_last1 = 1'b0;
        n = 0;
        while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_data1 = F2; in_last1 = 1'b1;
        @(negedge clk);
        n = 0;
        while (!in_ready1 && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1 in_valid1 = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid1 && lat < 20) begin @(negedge clk); lat++; end
        check("d1_sum_1_2", {32'd0, out_data1}, {32'd0, F3});
        check("d1_latency", 64'(lat), 64'd2);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
